// File: rtl/mux4to1_pkg.sv
// mux4to1_pkg: select code constants shared by the mux core and its register wrapper.
package mux4to1_pkg;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;

endpackage

// File: rtl/mux4to1_core.sv
// mux4to1_core: purely combinational 4:1 word mux; one select code drives every bit.
module mux4to1_core
    import mux4to1_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = (sel == SEL_A) ? a :
            (sel == SEL_B) ? b :
            (sel == SEL_C) ? c : d;
    end

endmodule

// File: rtl/mux4to1.sv
// mux4to1: 4:1 mux with registered output, registered select and a select-change pulse.
module mux4to1
    import mux4to1_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic             s1,
    input  logic             s2,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic [1:0]       sel_q,
    output logic             sel_chg
);

    logic [1:0] sel;

    assign sel = {s1, s2};

    mux4to1_core #(.WIDTH(WIDTH)) u_core (
        .a   (a),
        .b   (b),
        .c   (c),
        .d   (d),
        .sel (sel),
        .y   (y)
    );

    // sel_q resets to SEL_A, so a non-zero select on the first edge after reset flags a change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q     <= '0;
            sel_q   <= SEL_A;
            sel_chg <= 1'b0;
        end else begin
            y_q     <= y;
            sel_q   <= sel;
            sel_chg <= (sel != sel_q);
        end
    end

endmodule

// File: tb/tb_mux4to1.sv
// tb_mux4to1: directed vectors feed a scoreboard queue; a separate monitor pops and compares.
module tb_mux4to1;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] a = '0, b = '0, c = '0, d = '0;
    logic         s1 = 1'b0, s2 = 1'b0;
    logic [W-1:0] y, y_q;
    logic [1:0]   sel_q;
    logic         sel_chg;

    always #5 clk = ~clk;

    mux4to1 #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .c       (c),
        .d       (d),
        .s1      (s1),
        .s2      (s2),
        .y       (y),
        .y_q     (y_q),
        .sel_q   (sel_q),
        .sel_chg (sel_chg)
    );

    typedef struct {
        string        name;
        logic         chk_reg;
        logic [W-1:0] y;
        logic [W-1:0] y_q;
        logic [1:0]   sel_q;
        logic         chg;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    event sample;

    task automatic set_in(input logic [1:0] sel, input logic [W-1:0] va, vb, vc, vd);
        {s1, s2} = sel;
        a = va;
        b = vb;
        c = vc;
        d = vd;
    endtask

    task automatic expect_now(input string name, input logic chk_reg, input logic [W-1:0] ey, eyq,
                              input logic [1:0] esq, input logic ec);
        exp_t e;
        e.name    = name;
        e.chk_reg = chk_reg;
        e.y       = ey;
        e.y_q     = eyq;
        e.sel_q   = esq;
        e.chg     = ec;
        q.push_back(e);
        -> sample;
    endtask

    task automatic comb(input string name, input logic [1:0] sel, input logic [W-1:0] va, vb, vc, vd,
                        input logic [W-1:0] ey);
        @(negedge clk);
        set_in(sel, va, vb, vc, vd);
        expect_now(name, 1'b0, ey, '0, 2'b00, 1'b0);
    endtask

    task automatic rstep(input string name, input logic [1:0] sel, input logic [W-1:0] va, vb, vc, vd,
                         input logic [W-1:0] ey, eyq, input logic [1:0] esq, input logic ec);
        @(negedge clk);
        set_in(sel, va, vb, vc, vd);
        @(posedge clk);
        expect_now(name, 1'b1, ey, eyq, esq, ec);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(sample);
            #1;
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_underflow: sample with no expectation queued");
            end else begin
                e = q.pop_front();
                if (y !== e.y || (e.chk_reg && (y_q !== e.y_q || sel_q !== e.sel_q || sel_chg !== e.chg))) begin
                    failures++;
                    $display("FAIL %s: got y=%h y_q=%h sel_q=%b sel_chg=%b, want y=%h y_q=%h sel_q=%b sel_chg=%b (regs checked=%0b)",
                             e.name, y, y_q, sel_q, sel_chg, e.y, e.y_q, e.sel_q, e.chg, e.chk_reg);
                end
            end
        end
    end

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        expect_now("reset_hold", 1'b1, 4'h0, 4'h0, 2'b00, 1'b0);

        comb("sel_a_one",  2'b00, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1);
        comb("sel_b_one",  2'b01, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1);
        comb("sel_c_one",  2'b10, 4'h0, 4'h0, 4'h1, 4'h0, 4'h1);
        comb("sel_d_one",  2'b11, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1);
        comb("sel_a_zero", 2'b00, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0);
        comb("sel_b_zero", 2'b01, 4'h1, 4'h0, 4'h1, 4'h1, 4'h0);
        comb("sel_c_zero", 2'b10, 4'h1, 4'h1, 4'h0, 4'h1, 4'h0);
        comb("sel_d_zero", 2'b11, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0);
        comb("word_a",     2'b00, 4'hA, 4'h5, 4'h3, 4'hC, 4'hA);
        comb("word_b",     2'b01, 4'hA, 4'h5, 4'h3, 4'hC, 4'h5);
        comb("word_c",     2'b10, 4'hA, 4'h5, 4'h3, 4'hC, 4'h3);
        comb("word_d",     2'b11, 4'hA, 4'h5, 4'h3, 4'hC, 4'hC);

        @(negedge clk);
        rst = 1'b0;
        set_in(2'b00, 4'h0, 4'h0, 4'h0, 4'h0);
        @(posedge clk);
        expect_now("first_edge_sel00", 1'b1, 4'h0, 4'h0, 2'b00, 1'b0);

        rstep("sel_to_d",  2'b11, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 2'b11, 1'b1);
        rstep("hold_d",    2'b11, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 2'b11, 1'b0);
        rstep("to_b",      2'b01, 4'h0, 4'h6, 4'h0, 4'h0, 4'h6, 4'h6, 2'b01, 1'b1);
        rstep("data_only", 2'b01, 4'h0, 4'h7, 4'h0, 4'h0, 4'h7, 4'h7, 2'b01, 1'b0);
        rstep("sel_and_data", 2'b10, 4'h0, 4'h0, 4'h9, 4'h0, 4'h9, 4'h9, 2'b10, 1'b1);

        #3 rst = 1'b1;
        expect_now("async_rst", 1'b1, 4'h9, 4'h0, 2'b00, 1'b0);
        @(posedge clk);
        expect_now("rst_held_edge", 1'b1, 4'h9, 4'h0, 2'b00, 1'b0);

        @(negedge clk);
        rst = 1'b0;
        set_in(2'b10, 4'h0, 4'h0, 4'h5, 4'h0);
        @(posedge clk);
        expect_now("release_sel_c", 1'b1, 4'h5, 4'h5, 2'b10, 1'b1);

        repeat (2) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
